// File: rtl/axis_write_data.sv
// ---------------------------------------------------------------------------
// axis_write_data
//
// AXI write data channel engine. Takes a narrow stream of cfg_length words,
// packs WIDTH_RATIO consecutive words into one AXI beat, queues beats in a
// FIFO and presents them on the W channel through a one-beat output register.
// axi_wlast marks every BURST_LENGTH-th beat and the final beat of the
// transfer, so it lines up with the address block that issues the bursts.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_length   in   transfer length in stream words
//   cfg_valid    in   start request, only looked at while cfg_ready
//   cfg_ready    out  high while idle
//   data         in   stream word
//   valid        in   stream word present
//   ready        out  stream word taken when valid & ready
//   axi_wdata    out  W beat data
//   axi_wvalid   out  W beat valid
//   axi_wlast    out  last beat of the current burst
//   axi_wready   in   W beat accepted
//   done         out  one-cycle pulse once every beat is on the bus
// ---------------------------------------------------------------------------
module axis_write_data #(
   parameter int BUF_AWIDTH     = 9,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int WIDTH_RATIO    = 2,
   parameter int BURST_LENGTH   = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      valid,
   output logic                      ready,
   output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
   output logic                      axi_wvalid,
   output logic                      axi_wlast,
   input  logic                      axi_wready,
   output logic                      done
);

   localparam int FIFO_DEPTH = 1 << BUF_AWIDTH;
   localparam int FIFO_WIDTH = AXI_DATA_WIDTH + 1;
   localparam int LANE_W     = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;

   localparam logic [LANE_W-1:0]        LAST_LANE  = LANE_W'(WIDTH_RATIO - 1);
   localparam logic [LANE_W-1:0]        LANE_ONE   = LANE_W'(1);
   localparam logic [CONFIG_DWIDTH-1:0] CNT_ONE    = CONFIG_DWIDTH'(1);
   localparam logic [CONFIG_DWIDTH-1:0] RATIO_C    = CONFIG_DWIDTH'(WIDTH_RATIO);
   localparam logic [CONFIG_DWIDTH-1:0] BURST_LAST = CONFIG_DWIDTH'(BURST_LENGTH - 1);
   localparam logic [BUF_AWIDTH:0]      PTR_ONE    = (BUF_AWIDTH + 1)'(1);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ACTIVE = 4'b0010,
      DRAIN  = 4'b0100,
      DONE   = 4'b1000
   } state_t;

   state_t state;
   state_t state_next;

   // transfer bookkeeping
   logic [CONFIG_DWIDTH-1:0]  cfg_len_q;
   logic [CONFIG_DWIDTH-1:0]  total_beats_q;
   logic [CONFIG_DWIDTH-1:0]  word_cnt;
   logic [CONFIG_DWIDTH-1:0]  beat_cnt;
   logic [CONFIG_DWIDTH-1:0]  burst_cnt;
   logic [LANE_W-1:0]         lane_cnt;
   logic [AXI_DATA_WIDTH-1:0] pack_buf;

   // beat-count arithmetic for a new request
   logic [CONFIG_DWIDTH-1:0]  beats_quot;
   logic [CONFIG_DWIDTH-1:0]  beats_rem;
   logic [CONFIG_DWIDTH-1:0]  beats_calc;

   // stream side
   logic                      start;
   logic                      accept;
   logic                      last_word;
   logic                      push;
   logic                      push_last;
   logic [AXI_DATA_WIDTH-1:0] push_data;

   // FIFO and output register
   logic [FIFO_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
   logic [BUF_AWIDTH:0]       wr_ptr;
   logic [BUF_AWIDTH:0]       rd_ptr;
   logic [FIFO_WIDTH-1:0]     fifo_rdata;
   logic                      fifo_empty;
   logic                      buf_full;
   logic                      out_free;
   logic                      pop;

   // ceil(cfg_length / WIDTH_RATIO) written as quotient plus a carry for a
   // partial beat, so cfg_length near the top of its range cannot overflow.
   assign beats_quot = cfg_length / RATIO_C;
   assign beats_rem  = cfg_length % RATIO_C;
   assign beats_calc = beats_quot + ((beats_rem != '0) ? CNT_ONE : '0);

   assign start  = (state == IDLE) & cfg_valid;
   assign ready  = (state == ACTIVE) & ~buf_full & (word_cnt != cfg_len_q);
   assign accept = valid & ready;

   // Only meaningful while accepting, which already implies word_cnt is below
   // cfg_len_q, so the subtraction never wraps when it matters.
   assign last_word = (word_cnt == (cfg_len_q - CNT_ONE));

   // A beat leaves the packer when its top lane fills or the transfer ends
   // early; lanes above the final word stay zero because pack_buf is cleared
   // after every push.
   assign push      = accept & ((lane_cnt == LAST_LANE) | last_word);
   assign push_last = (burst_cnt == BURST_LAST) | (beat_cnt == (total_beats_q - CNT_ONE));

   // Merge the incoming word into its lane on top of the partially built beat.
   always_comb begin
      push_data = pack_buf;
      for (int k = 0; k < WIDTH_RATIO; k++) begin
         if (lane_cnt == LANE_W'(k)) begin
            push_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
         end
      end
   end

   // Counters and the lane packer. A new request clears everything so each
   // transfer starts on a fresh burst boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_len_q     <= '0;
         total_beats_q <= '0;
         word_cnt      <= '0;
         beat_cnt      <= '0;
         burst_cnt     <= '0;
         lane_cnt      <= '0;
         pack_buf      <= '0;
      end else if (start) begin
         cfg_len_q     <= cfg_length;
         total_beats_q <= beats_calc;
         word_cnt      <= '0;
         beat_cnt      <= '0;
         burst_cnt     <= '0;
         lane_cnt      <= '0;
         pack_buf      <= '0;
      end else if (accept) begin
         word_cnt <= word_cnt + CNT_ONE;
         if (push) begin
            pack_buf  <= '0;
            lane_cnt  <= '0;
            beat_cnt  <= beat_cnt + CNT_ONE;
            burst_cnt <= (burst_cnt == BURST_LAST) ? '0 : (burst_cnt + CNT_ONE);
         end else begin
            pack_buf <= push_data;
            lane_cnt <= lane_cnt + LANE_ONE;
         end
      end
   end

   // FIFO storage. wlast rides along with the beat so the output side never
   // has to know about burst boundaries.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[BUF_AWIDTH-1:0]] <= {push_last, push_data};
      end
   end

   assign fifo_rdata = fifo_mem[rd_ptr[BUF_AWIDTH-1:0]];

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // without a separate occupancy counter.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign buf_full   = (wr_ptr[BUF_AWIDTH] != rd_ptr[BUF_AWIDTH]) &&
                       (wr_ptr[BUF_AWIDTH-1:0] == rd_ptr[BUF_AWIDTH-1:0]);

   // The output register can take a new beat when it is empty or its current
   // beat is being handshaken this cycle, which keeps beats back to back.
   assign out_free = ~axi_wvalid | axi_wready;
   assign pop      = ~fifo_empty & out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // W channel output register; data and last only change on a load, so they
   // hold steady for as long as the interconnect stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         axi_wvalid <= 1'b0;
         axi_wdata  <= '0;
         axi_wlast  <= 1'b0;
      end else if (pop) begin
         axi_wvalid <= 1'b1;
         axi_wlast  <= fifo_rdata[AXI_DATA_WIDTH];
         axi_wdata  <= fifo_rdata[AXI_DATA_WIDTH-1:0];
      end else if (axi_wready) begin
         axi_wvalid <= 1'b0;
         axi_wlast  <= 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and status outputs. ACTIVE leaves on the edge that takes the
   // final word (or at once for an empty transfer); DRAIN leaves on the edge
   // where the last beat is handshaken with nothing left behind it.
   always_comb begin
      state_next = state;
      cfg_ready  = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if ((word_cnt == cfg_len_q) || (accept && last_word)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && out_free) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_write_data.sv
// ---------------------------------------------------------------------------
// tb_axis_write_data
//
// Self-checking bench for axis_write_data. Each transfer builds its word list,
// derives the expected W beats (packing, zero fill, wlast positions) straight
// from word indices, then runs a stream driver and a W-channel sink side by
// side. The sink compares every handshaken beat in order, checks that a
// stalled beat holds steady, and counts done pulses.
// ---------------------------------------------------------------------------
module tb_axis_write_data;

   localparam int BUF_AWIDTH     = 9;
   localparam int CONFIG_DWIDTH  = 32;
   localparam int WIDTH_RATIO    = 2;
   localparam int BURST_LENGTH   = 16;
   localparam int DATA_WIDTH     = 32;
   localparam int AXI_DATA_WIDTH = 64;
   localparam int FIFO_DEPTH     = 1 << BUF_AWIDTH;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [CONFIG_DWIDTH-1:0]  cfg_length;
   logic                      cfg_valid;
   logic                      cfg_ready;
   logic [DATA_WIDTH-1:0]     data;
   logic                      valid;
   logic                      ready;
   logic [AXI_DATA_WIDTH-1:0] axi_wdata;
   logic                      axi_wvalid;
   logic                      axi_wlast;
   logic                      axi_wready;
   logic                      done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference data for the transfer in flight
   logic [DATA_WIDTH-1:0]       words_q[$];
   logic [AXI_DATA_WIDTH:0]     exp_q[$];

   // observations from the most recent transfer
   int                          last_first_fill;
   int                          last_first_beat;
   int                          last_max_gap;
   int                          last_full_words;
   int                          last_wlast_cnt;
   logic [AXI_DATA_WIDTH-1:0]   cap [0:3];

   axis_write_data #(
      .BUF_AWIDTH    (BUF_AWIDTH),
      .CONFIG_DWIDTH (CONFIG_DWIDTH),
      .WIDTH_RATIO   (WIDTH_RATIO),
      .BURST_LENGTH  (BURST_LENGTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_length(cfg_length),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .axi_wdata (axi_wdata),
      .axi_wvalid(axi_wvalid),
      .axi_wlast (axi_wlast),
      .axi_wready(axi_wready),
      .done      (done)
   );

   // free-running clock and cycle counter used for latency measurements
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // one comparison: counts it, and on mismatch counts and reports it
   task automatic checkOutput(input string tag, input logic [95:0] observed,
                              input logic [95:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // expected beats: word i goes to beat i/R, lane i%R; missing lanes are
   // zero; wlast on every BURST_LENGTH-th beat and on the final beat
   task automatic buildModel(input int len);
      int nbeats;
      int idx;
      logic [AXI_DATA_WIDTH-1:0] beat;
      logic last;
      exp_q.delete();
      nbeats = (len + WIDTH_RATIO - 1) / WIDTH_RATIO;
      for (int b = 0; b < nbeats; b++) begin
         beat = '0;
         for (int k = 0; k < WIDTH_RATIO; k++) begin
            idx = b * WIDTH_RATIO + k;
            if (idx < len) beat[k*DATA_WIDTH +: DATA_WIDTH] = words_q[idx];
         end
         last = ((b % BURST_LENGTH) == BURST_LENGTH - 1) || (b == nbeats - 1);
         exp_q.push_back({last, beat});
      end
   endtask

   // one complete transfer: request, stream words, collect beats, see done
   task automatic applyStimulus(input int len, input bit directed, input int stall_pct,
                                input int gap_pct, input bit fill_test, input bit poke_cfg);
      int  acc_cnt;
      int  beat_cnt;
      int  done_cnt;
      int  nbeats;
      bit  driver_done;
      bit  sink_done;
      bit  stalled;
      int  last_hs;

      words_q.delete();
      for (int i = 0; i < len; i++) words_q.push_back(directed ? DATA_WIDTH'(i + 1) : DATA_WIDTH'($urandom));
      buildModel(len);
      nbeats          = exp_q.size();
      acc_cnt         = 0;
      beat_cnt        = 0;
      done_cnt        = 0;
      driver_done     = 0;
      sink_done       = 0;
      stalled         = 0;
      last_hs         = -1;
      last_first_fill = -1;
      last_first_beat = -1;
      last_max_gap    = 0;
      last_full_words = -1;
      last_wlast_cnt  = 0;

      @(negedge clk);
      checkOutput("cfg_ready_idle", cfg_ready, 1);
      cfg_length = len;
      cfg_valid  = 1'b1;
      @(negedge clk);
      cfg_valid  = 1'b0;
      cfg_length = $urandom;
      checkOutput("cfg_ready_busy", cfg_ready, 0);

      fork
         begin : drive_stream
            int guard;
            int idle_run;
            guard    = 0;
            idle_run = 0;
            while (acc_cnt < len && guard < 20000) begin
               guard++;
               valid = ($urandom_range(99) >= gap_pct);
               data  = words_q[acc_cnt];
               if (poke_cfg && acc_cnt == 1) begin
                  cfg_valid  = 1'b1;
                  cfg_length = 7;
               end else begin
                  cfg_valid  = 1'b0;
               end
               #1;
               if (valid && ready) begin
                  if (acc_cnt == WIDTH_RATIO - 1) last_first_fill = cyc;
                  acc_cnt++;
                  idle_run = 0;
               end else if (valid) begin
                  idle_run++;
                  if (fill_test && idle_run == 10 && !stalled) begin
                     stalled         = 1;
                     last_full_words = acc_cnt;
                  end
               end
               @(negedge clk);
            end
            valid     = 1'b0;
            cfg_valid = 1'b0;
            if (acc_cnt < len) checkOutput("driver_timeout", acc_cnt, len);
            driver_done = 1;
         end
         begin : sink_beats
            int guard;
            bit prev_stall;
            bit done_prev;
            logic [AXI_DATA_WIDTH:0] prev_beat;
            guard      = 0;
            prev_stall = 0;
            done_prev  = 0;
            prev_beat  = '0;
            while (!sink_done && guard < 30000) begin
               guard++;
               if (fill_test && !stalled) axi_wready = 1'b0;
               else axi_wready = ($urandom_range(99) >= stall_pct);
               #1;
               if (prev_stall) begin
                  checkOutput("wvalid_held", axi_wvalid, 1);
                  checkOutput("wbeat_stable", {axi_wlast, axi_wdata}, prev_beat);
               end
               prev_stall = axi_wvalid && !axi_wready;
               prev_beat  = {axi_wlast, axi_wdata};
               if (axi_wvalid && last_first_beat < 0) last_first_beat = cyc;
               if (axi_wvalid && axi_wready) begin
                  if (exp_q.size() == 0) checkOutput("unexpected_beat", beat_cnt, nbeats - 1);
                  else checkOutput($sformatf("beat%0d", beat_cnt), {axi_wlast, axi_wdata}, exp_q.pop_front());
                  if (beat_cnt < 4) cap[beat_cnt] = axi_wdata;
                  if (axi_wlast) last_wlast_cnt++;
                  if (last_hs >= 0 && (cyc - last_hs) > last_max_gap) last_max_gap = cyc - last_hs;
                  last_hs = cyc;
                  beat_cnt++;
               end
               if (done_prev) begin
                  checkOutput("done_one_cycle", done, 0);
                  checkOutput("cfg_ready_after_done", cfg_ready, 1);
                  sink_done = 1;
               end
               if (done) begin
                  done_cnt++;
                  done_prev = 1;
               end
               @(negedge clk);
            end
            if (!sink_done) checkOutput("done_timeout", done_cnt, 1);
         end
      join
      axi_wready = 1'b0;
      checkOutput("beat_count", beat_cnt, nbeats);
      checkOutput("done_pulses", done_cnt, 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_length = '0;
      valid      = 1'b0;
      data       = '0;
      axi_wready = 1'b0;

      #12;
      checkOutput("rst_cfg_ready", cfg_ready, 1);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_wvalid", axi_wvalid, 0);
      checkOutput("rst_wlast", axi_wlast, 0);
      checkOutput("rst_wdata", axi_wdata, 0);
      checkOutput("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // four words 1..4 at full rate: two packed beats, 2-cycle latency
      applyStimulus(4, 1, 0, 0, 0, 0);
      checkOutput("lat_fill_to_wvalid", last_first_beat - last_first_fill, 2);
      checkOutput("len4_beat0", cap[0], 64'h00000002_00000001);
      checkOutput("len4_beat1", cap[1], 64'h00000004_00000003);
      checkOutput("len4_wlast_cnt", last_wlast_cnt, 1);

      // odd length: final beat zero-filled in the upper lane
      applyStimulus(5, 1, 0, 0, 0, 0);
      checkOutput("len5_beat2", cap[2], 64'h00000000_00000005);

      // 20 beats: wlast on beats 15 and 19, no bubbles at full rate
      applyStimulus(40, 1, 0, 0, 0, 0);
      checkOutput("len40_wlast_cnt", last_wlast_cnt, 2);
      checkOutput("len40_beat_spacing", last_max_gap, WIDTH_RATIO);

      // empty transfer, then a request poked while ACTIVE must be ignored
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(6, 0, 30, 20, 0, 1);

      // random lengths with random backpressure on both sides
      for (int t = 0; t < 6; t++) begin
         applyStimulus($urandom_range(1, 70), 0, $urandom_range(0, 60), $urandom_range(0, 50), 0, 0);
      end

      // stall the W channel until the stream side stops: FIFO full plus the
      // beat already parked in the output register
      applyStimulus(1100, 0, 20, 0, 1, 0);
      checkOutput("fill_words_accepted", last_full_words, (FIFO_DEPTH + 1) * WIDTH_RATIO);

      // reset in the middle of a transfer while a beat is being offered
      @(negedge clk);
      cfg_length = 20;
      cfg_valid  = 1'b1;
      @(negedge clk);
      cfg_valid  = 1'b0;
      axi_wready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         valid = 1'b1;
         data  = $urandom;
         @(negedge clk);
      end
      valid = 1'b0;
      checkOutput("wvalid_before_reset", axi_wvalid, 1);
      checkOutput("ready_before_reset", ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_wvalid", axi_wvalid, 0);
      checkOutput("async_rst_ready", ready, 0);
      checkOutput("async_rst_cfg_ready", cfg_ready, 1);
      checkOutput("async_rst_wdata", axi_wdata, 0);
      checkOutput("async_rst_wlast", axi_wlast, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(4, 1, 0, 0, 0, 0);
      checkOutput("post_rst_beat0", cap[0], 64'h00000002_00000001);
      checkOutput("post_rst_beat1", cap[1], 64'h00000004_00000003);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
